// File: rtl/pcm_encoder.sv
// pcm_encoder
//   Serial PCM transmit encoder. Takes NRZ-L bits at the symbol rate and
//   applies optional inversion, randomizing (x^15+x^14+1, self-synchronizing),
//   NRZ-L/M/S differential coding and biphase splitting. A PN15 generator can
//   stand in for the input data during BER/loopback testing.
//
// Ports
//   clk           system clock, rising edge
//   rs_n          asynchronous active-low reset
//   enc_en        encoder enable; low synchronously returns all state to reset
//   bit_clk_en    bit-rate strobe (always coincident with bit_clk_2x_en)
//   bit_clk_2x_en half-bit-rate strobe
//   din           NRZ-L data bit, consumed when din_req is high
//   mode          00 NRZ-L, 01 NRZ-M, 10 NRZ-S, 11 NRZ-L
//   biphase       1 = split each bit into two halves (Bi-L/M/S)
//   randomize     1 = randomized NRZ-L enabled
//   data_inv      1 = invert the source bit
//   test_mode     1 = PN15 generator replaces din
//   din_req       combinational: din is consumed this cycle
//   dout          registered serial encoded data
//   cout          combinational output strobe (bit or half-bit rate)

module pcm_encoder #(
  parameter logic [14:0] PN_SEED = 15'h7fff
) (
  input  logic       clk,
  input  logic       rs_n,
  input  logic       enc_en,
  input  logic       bit_clk_en,
  input  logic       bit_clk_2x_en,
  input  logic       din,
  input  logic [1:0] mode,
  input  logic       biphase,
  input  logic       randomize,
  input  logic       data_inv,
  input  logic       test_mode,
  output logic       din_req,
  output logic       dout,
  output logic       cout
);

  localparam logic [1:0] MODE_NRZM = 2'b01;
  localparam logic [1:0] MODE_NRZS = 2'b10;

  logic [14:0] pn_reg;
  logic [14:0] t_reg;
  logic        last_reg;
  logic        hold_reg;
  logic        dout_reg;

  logic        src_bit;
  logic        inv_bit;
  logic        rnd_bit;
  logic        enc_bit;

  // Encoder datapath for the bit currently presented; only committed to
  // state on bit_clk_en.
  always_comb begin
    src_bit = test_mode ? pn_reg[14] : din;
    inv_bit = src_bit ^ data_inv;
    rnd_bit = randomize ? (inv_bit ^ t_reg[14] ^ t_reg[13]) : inv_bit;
    unique case (mode)
      MODE_NRZM: enc_bit = rnd_bit ^ last_reg;
      MODE_NRZS: enc_bit = ~rnd_bit ^ last_reg;
      default:   enc_bit = rnd_bit;
    endcase
  end

  assign din_req = enc_en & bit_clk_en & ~test_mode;
  assign cout    = enc_en & (biphase ? bit_clk_2x_en : bit_clk_en);
  assign dout    = dout_reg;

  always_ff @(posedge clk or negedge rs_n) begin
    if (!rs_n) begin
      pn_reg   <= PN_SEED;
      t_reg    <= '0;
      last_reg <= 1'b0;
      hold_reg <= 1'b0;
      dout_reg <= 1'b0;
    end else if (!enc_en) begin
      // Disable behaves as a synchronous reset so a re-enabled stream always
      // starts on a fresh first half with clean differential/scrambler state.
      pn_reg   <= PN_SEED;
      t_reg    <= '0;
      last_reg <= 1'b0;
      hold_reg <= 1'b0;
      dout_reg <= 1'b0;
    end else begin
      if (bit_clk_en) begin
        if (randomize) begin
          t_reg <= {t_reg[13:0], rnd_bit};
        end
        last_reg <= enc_bit;
        if (test_mode) begin
          pn_reg <= {pn_reg[13:0], pn_reg[14] ^ pn_reg[13]};
        end
      end
      // Output stage runs on the half-bit strobe only; a lone bit_clk_en
      // advances the encoder but leaves dout untouched.
      if (bit_clk_2x_en) begin
        if (bit_clk_en) begin
          hold_reg <= enc_bit;
          dout_reg <= enc_bit;
        end else if (biphase) begin
          // Second half uses the held bit so a config change mid-bit cannot
          // corrupt the transition.
          dout_reg <= ~hold_reg;
        end
      end
    end
  end

endmodule
